// File: rtl/cnt_inc_sched_pkg.sv
// Shared types and helpers for the increment scheduler.
//   state_t   : scheduler FSM states
//   ID_W      : source-id width for the default four-source configuration
//   pend_step : next value and overflow flag of one pending counter
package cnt_sched_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GAP  = 1'b1
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int ID_W      = $clog2(N_REQ_DEF);

  typedef struct packed {
    logic        ovf;
    logic [15:0] nxt;
  } pend_upd_t;

  // Pending counters are at most 16 bits wide; callers zero-extend into this
  // helper and truncate the result. A request together with a grant is a
  // net-zero change, so it can never overflow even at the maximum.
  function automatic pend_upd_t pend_step(input logic [15:0] cur,
                                          input logic [15:0] maxv,
                                          input logic        r,
                                          input logic        g);
    pend_upd_t u;
    u.ovf = 1'b0;
    u.nxt = cur;
    if (r && !g) begin
      if (cur == maxv) u.ovf = 1'b1;
      else             u.nxt = cur + 16'd1;
    end else if (g && !r) begin
      u.nxt = cur - 16'd1;
    end
    return u;
  endfunction

endpackage

// File: rtl/cnt_inc_sched_rr_pick.sv
// Combinational round-robin picker.
//   cand : candidate vector, one bit per source
//   ptr  : id of the last source served; search starts at ptr+1 and wraps
//   gnt  : one-hot grant (all zero when no candidate)
//   id   : encoded id of the granted source (0 when no candidate)
//   any  : at least one candidate present
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   cand,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] id,
  output logic           any
);

  logic [IDW-1:0] idx;

  // Walk from lowest priority (ptr itself) up to highest (ptr+1); the last
  // hit overwrites earlier ones, so the highest-priority candidate wins.
  always_comb begin
    gnt = '0;
    id  = '0;
    idx = '0;
    any = |cand;
    for (int k = N; k >= 1; k--) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (cand[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        id       = idx;
      end
    end
  end

endmodule

// File: rtl/cnt_inc_sched.sv
// Schedules increment requests from N_REQ sources onto a single registered
// inc pulse, round-robin, with at least GAP cycles between inc rising edges.
//   clk, rst   : clock and synchronous active-high reset
//   req        : per-source request strobes (one request per high cycle)
//   clr_ovf    : clears all sticky overflow flags
//   inc        : one-cycle increment pulse to the downstream counter
//   grant_id   : source served by the current inc; held while inc is low
//   issued_cnt : number of inc pulses issued, modulo 2^CNT_W
//   pend_ovf   : sticky per-source flag, a request was dropped
//   busy       : any request pending or spacing gap still running
module cnt_inc_sched
  import cnt_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int PEND_W = 4,
  parameter int GAP    = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     clr_ovf,
  output logic                     inc,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [CNT_W-1:0]         issued_cnt,
  output logic [N_REQ-1:0]         pend_ovf,
  output logic                     busy
);

  localparam int                IDW      = $clog2(N_REQ);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [7:0]        GAP_LOAD = (GAP > 1) ? 8'(GAP - 2) : 8'd0;

  state_t            state, state_n;
  logic [7:0]        gap_cnt, gap_n;
  logic [IDW-1:0]    rr_ptr;
  logic [PEND_W-1:0] pend   [N_REQ];
  logic [PEND_W-1:0] pend_n [N_REQ];
  pend_upd_t         upd    [N_REQ];
  logic [N_REQ-1:0]  cand, pick_oh, gnt, ovf_new;
  logic [IDW-1:0]    pick_id;
  logic              pick_any, grant_en;

  always_comb begin
    cand = '0;
    for (int i = 0; i < N_REQ; i++) cand[i] = |pend[i];
  end

  rr_pick #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_pick (
    .cand (cand),
    .ptr  (rr_ptr),
    .gnt  (pick_oh),
    .id   (pick_id),
    .any  (pick_any)
  );

  // Grant only from S_IDLE; S_GAP enforces the pulse spacing.
  always_comb begin
    state_n  = state;
    gap_n    = gap_cnt;
    grant_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_any) begin
          grant_en = 1'b1;
          if (GAP > 1) begin
            state_n = S_GAP;
            gap_n   = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == 8'd0) state_n = S_IDLE;
        else                 gap_n   = gap_cnt - 8'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign gnt = grant_en ? pick_oh : '0;

  always_comb begin
    ovf_new = '0;
    for (int i = 0; i < N_REQ; i++) begin
      upd[i]     = pend_step(16'(pend[i]), 16'(PEND_MAX), req[i], gnt[i]);
      pend_n[i]  = upd[i].nxt[PEND_W-1:0];
      ovf_new[i] = upd[i].ovf;
    end
  end

  assign busy = pick_any || (state == S_GAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      gap_cnt    <= '0;
      rr_ptr     <= IDW'(N_REQ - 1);
      inc        <= 1'b0;
      grant_id   <= '0;
      issued_cnt <= '0;
      pend_ovf   <= '0;
      for (int i = 0; i < N_REQ; i++) pend[i] <= '0;
    end else begin
      state    <= state_n;
      gap_cnt  <= gap_n;
      inc      <= grant_en;
      // A new overflow beats a simultaneous clear for that bit.
      pend_ovf <= (clr_ovf ? '0 : pend_ovf) | ovf_new;
      for (int i = 0; i < N_REQ; i++) pend[i] <= pend_n[i];
      if (grant_en) begin
        grant_id   <= pick_id;
        rr_ptr     <= pick_id;
        issued_cnt <= issued_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnt_inc_sched.sv
// Directed bench for cnt_inc_sched. Three instances share the clock:
//   u_a GAP=2, u_b GAP=1, u_c GAP=4 (all N_REQ=4, PEND_W=4, CNT_W=8).
// Inputs are driven and outputs sampled on the falling edge; "cycle t"
// is the t-th falling edge of a scenario loop.
module tb_cnt_inc_sched;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rst_c;
  logic [3:0] req_a, req_b, req_c;
  logic       clr_a, clr_b, clr_c;
  logic       inc_a, inc_b, inc_c;
  logic [1:0] gid_a, gid_b, gid_c;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [3:0] ovf_a, ovf_b, ovf_c;
  logic       busy_a, busy_b, busy_c;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cnt_inc_sched #(.N_REQ(4), .PEND_W(4), .GAP(2), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst_a), .req(req_a), .clr_ovf(clr_a), .inc(inc_a),
    .grant_id(gid_a), .issued_cnt(cnt_a), .pend_ovf(ovf_a), .busy(busy_a));

  cnt_inc_sched #(.N_REQ(4), .PEND_W(4), .GAP(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst_b), .req(req_b), .clr_ovf(clr_b), .inc(inc_b),
    .grant_id(gid_b), .issued_cnt(cnt_b), .pend_ovf(ovf_b), .busy(busy_b));

  cnt_inc_sched #(.N_REQ(4), .PEND_W(4), .GAP(4), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst_c), .req(req_c), .clr_ovf(clr_c), .inc(inc_c),
    .grant_id(gid_c), .issued_cnt(cnt_c), .pend_ovf(ovf_c), .busy(busy_c));

  task automatic pulse_rst(input int which);
    @(negedge clk);
    if (which == 0) rst_a = 1'b1;
    if (which == 1) rst_c = 1'b1;
    if (which == 2) rst_b = 1'b1;
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    req_a = '0; req_b = '0; req_c = '0;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    total_cnt++;
    if (inc_a !== 1'b0) $display("FAIL reset_inc got=%b exp=0", inc_a); else pass_cnt++;
    total_cnt++;
    if (gid_a !== 2'd0) $display("FAIL reset_gid got=%0d exp=0", gid_a); else pass_cnt++;
    total_cnt++;
    if (cnt_a !== 8'd0 || cnt_b !== 8'd0 || cnt_c !== 8'd0)
      $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0", cnt_a, cnt_b, cnt_c);
    else pass_cnt++;
    total_cnt++;
    if (ovf_a !== 4'd0) $display("FAIL reset_ovf got=%b exp=0000", ovf_a); else pass_cnt++;
    total_cnt++;
    if (busy_a !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_a); else pass_cnt++;
  endtask

  task automatic test_single;
    logic [7:0] iv, bv;
    logic [1:0] g2;
    iv = '0; bv = '0; g2 = '0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      iv = {inc_a, iv[7:1]};
      bv = {busy_a, bv[7:1]};
      if (t == 2) g2 = gid_a;
      req_a = (t == 0) ? 4'b0100 : 4'b0000;
    end
    total_cnt++;
    if (iv !== 8'b0000_0100) $display("FAIL single_inc got=%b exp=00000100", iv); else pass_cnt++;
    total_cnt++;
    if (g2 !== 2'd2) $display("FAIL single_gid got=%0d exp=2", g2); else pass_cnt++;
    total_cnt++;
    if (cnt_a !== 8'd1) $display("FAIL single_cnt got=%0d exp=1", cnt_a); else pass_cnt++;
    total_cnt++;
    if (bv[2:1] !== 2'b11 || bv[7:4] !== 4'b0000)
      $display("FAIL single_busy got=%b exp=0000x11x", bv);
    else pass_cnt++;
  endtask

  task automatic test_all_four;
    logic [11:0] iv;
    logic [7:0]  gs;
    iv = '0; gs = '0;
    pulse_rst(0);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      iv = {inc_a, iv[11:1]};
      if (t == 2 || t == 4 || t == 6 || t == 8) gs = {gid_a, gs[7:2]};
      req_a = (t == 0) ? 4'b1111 : 4'b0000;
    end
    total_cnt++;
    if (iv !== 12'b0001_0101_0100) $display("FAIL all4_inc got=%b exp=000101010100", iv); else pass_cnt++;
    total_cnt++;
    if (gs !== 8'b11_10_01_00) $display("FAIL all4_gid got=%b exp=11100100", gs); else pass_cnt++;
    total_cnt++;
    if (cnt_a !== 8'd4) $display("FAIL all4_cnt got=%0d exp=4", cnt_a); else pass_cnt++;
    total_cnt++;
    if (ovf_a !== 4'd0 || busy_a !== 1'b0)
      $display("FAIL all4_idle got ovf=%b busy=%b exp ovf=0000 busy=0", ovf_a, busy_a);
    else pass_cnt++;
  endtask

  task automatic test_gap1;
    logic [15:0] iv;
    logic [1:0]  g11, g12;
    iv = '0; g11 = '0; g12 = '0;
    pulse_rst(2);
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      iv = {inc_b, iv[15:1]};
      if (t == 11) g11 = gid_b;
      if (t == 12) g12 = gid_b;
      req_b = (t < 10) ? 4'b0001 : (t == 10) ? 4'b1000 : 4'b0000;
    end
    total_cnt++;
    if (iv !== 16'b0001_1111_1111_1100) $display("FAIL gap1_inc got=%b exp=0001111111111100", iv); else pass_cnt++;
    total_cnt++;
    if (g11 !== 2'd0 || g12 !== 2'd3) $display("FAIL gap1_gid got=%0d,%0d exp=0,3", g11, g12); else pass_cnt++;
    total_cnt++;
    if (cnt_b !== 8'd11) $display("FAIL gap1_cnt got=%0d exp=11", cnt_b); else pass_cnt++;
  endtask

  task automatic test_overflow;
    pulse_rst(1);
    // req[1] held 30 cycles: 23 accepted, 7 dropped once pend saturates.
    for (int t = 0; t <= 100; t++) begin
      @(negedge clk);
      if (t == 20) begin
        total_cnt++;
        if (u_c.pend[1] !== 4'd15) $display("FAIL ovf_fill got=%0d exp=15", u_c.pend[1]); else pass_cnt++;
        total_cnt++;
        if (ovf_c !== 4'b0000) $display("FAIL ovf_early got=%b exp=0000", ovf_c); else pass_cnt++;
      end
      if (t == 21) begin
        total_cnt++;
        if (ovf_c !== 4'b0010) $display("FAIL ovf_set got=%b exp=0010", ovf_c); else pass_cnt++;
      end
      if (t == 95) begin
        total_cnt++;
        if (cnt_c !== 8'd23) $display("FAIL ovf_conserve got=%0d exp=23", cnt_c); else pass_cnt++;
        total_cnt++;
        if (u_c.pend[1] !== 4'd0 || busy_c !== 1'b0)
          $display("FAIL ovf_drain got pend=%0d busy=%b exp 0 0", u_c.pend[1], busy_c);
        else pass_cnt++;
        total_cnt++;
        if (ovf_c !== 4'b0010) $display("FAIL ovf_sticky got=%b exp=0010", ovf_c); else pass_cnt++;
      end
      if (t == 97) begin
        total_cnt++;
        if (ovf_c !== 4'b0000) $display("FAIL ovf_clear got=%b exp=0000", ovf_c); else pass_cnt++;
      end
      req_c = (t < 30) ? 4'b0010 : 4'b0000;
      clr_c = (t == 96);
    end
    // Refill: clear coincides with the first drop, then saturation corner
    // with requests only in grant cycles (grants at 29,33,37,41).
    for (int t = 0; t <= 115; t++) begin
      @(negedge clk);
      if (t == 20) begin
        total_cnt++;
        if (ovf_c !== 4'b0000) $display("FAIL ovf2_pre got=%b exp=0000", ovf_c); else pass_cnt++;
      end
      if (t == 21) begin
        total_cnt++;
        if (ovf_c !== 4'b0010) $display("FAIL ovf_set_wins got=%b exp=0010", ovf_c); else pass_cnt++;
      end
      if (t == 31) begin
        total_cnt++;
        if (ovf_c !== 4'b0000) $display("FAIL ovf2_clear got=%b exp=0000", ovf_c); else pass_cnt++;
      end
      if (t == 42) begin
        total_cnt++;
        if (u_c.pend[1] !== 4'd15 || ovf_c !== 4'b0000)
          $display("FAIL sat_corner got pend=%0d ovf=%b exp 15 0000", u_c.pend[1], ovf_c);
        else pass_cnt++;
      end
      if (t == 115) begin
        total_cnt++;
        if (cnt_c !== 8'd49 || busy_c !== 1'b0)
          $display("FAIL ovf2_total got cnt=%0d busy=%b exp 49 0", cnt_c, busy_c);
        else pass_cnt++;
      end
      req_c = (t < 30 || t == 33 || t == 37 || t == 41) ? 4'b0010 : 4'b0000;
      clr_c = (t == 20 || t == 30);
    end
  endtask

  task automatic test_wrap;
    int n;
    n = 0;
    pulse_rst(0);
    for (int t = 0; t < 780; t++) begin
      @(negedge clk);
      if (inc_a === 1'b1) n++;
      req_a = (t < 777 && (t % 3) == 0) ? 4'b0001 : 4'b0000;
    end
    total_cnt++;
    if (n !== 259) $display("FAIL wrap_incs got=%0d exp=259", n); else pass_cnt++;
    total_cnt++;
    if (cnt_a !== 8'd3) $display("FAIL wrap_cnt got=%0d exp=3", cnt_a); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    @(negedge clk);
    req_a = 4'b0111;
    @(negedge clk);
    total_cnt++;
    if (busy_a !== 1'b1) $display("FAIL mid_busy_pre got=%b exp=1", busy_a); else pass_cnt++;
    req_a = 4'b0000;
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    total_cnt++;
    if (inc_a !== 1'b0) $display("FAIL mid_inc got=%b exp=0", inc_a); else pass_cnt++;
    total_cnt++;
    if (cnt_a !== 8'd0) $display("FAIL mid_cnt got=%0d exp=0", cnt_a); else pass_cnt++;
    total_cnt++;
    if (busy_a !== 1'b0 || u_c.pend[0] !== 4'd0 || u_a.pend[1] !== 4'd0 || u_a.pend[2] !== 4'd0)
      $display("FAIL mid_pend got busy=%b p1=%0d p2=%0d exp 0", busy_a, u_a.pend[1], u_a.pend[2]);
    else pass_cnt++;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (inc_a === 1'b1) n++;
    end
    total_cnt++;
    if (n !== 0) $display("FAIL mid_no_inc got=%0d exp=0", n); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_gap1();
    test_overflow();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cnt_inc_sched.md
Name: cnt_inc_sched

Overview:
Schedules increment events from N_REQ independent sources onto the single `inc` input of the cross-clock-domain counter (CrossClkCnt) in the same clock domain as its source side. Buffers bursts in per-source pending counters. Grants round-robin, one increment per pulse, and enforces a minimum spacing between pulses so the downstream clock-crossing can absorb every change. Keeps a local mirror of the issued count so software and benches can compare it against the counter's outputs.

Parameters:
N_REQ, 4, number of requesting sources (2..16)
PEND_W, 4, width of each per-source pending counter; saturates at 2^PEND_W-1
GAP, 2, minimum cycles between successive inc rising edges (1 = back-to-back allowed)
CNT_W, 8, width of issued_cnt mirror; matches downstream counter width

Ports:
clk  input  1  single clock, same domain as downstream counter source side
rst  input  1  synchronous, active-high reset
req  input  N_REQ  per-source event strobe; each high cycle = one increment request
clr_ovf  input  1  clears all pend_ovf flags
inc  output  1  registered increment pulse to downstream counter
grant_id  output  $clog2(N_REQ)  source served by current inc; valid when inc=1
issued_cnt  output  CNT_W  count of inc pulses issued, modulo 2^CNT_W
pend_ovf  output  N_REQ  sticky per-source flag: a request was dropped
busy  output  1  any pending counter nonzero, or FSM in S_GAP

Behaviour:
- Reset (sync, rst=1 at edge):
  - all pend[i]=0, pend_ovf=0, inc=0, grant_id=0, issued_cnt=0
  - rr pointer = N_REQ-1, so source 0 has first priority
  - gap counter = 0, state = S_IDLE
  - Reset mid-operation discards all pending requests; no inc is issued on the cycle after reset.
- Pending update per edge: pend[i] <= pend[i] + req[i] - gnt[i].
  - gnt[i] is this cycle's grant, decided from the registered pend.
  - req with simultaneous gnt: net zero, never an overflow, even at max.
  - req without gnt while pend[i]==max: request dropped, pend stays max, pend_ovf[i] <= 1.
- pend_ovf: sticky. clr_ovf clears all bits. If a new overflow occurs in the same cycle as clr_ovf, set wins for that bit.
- Arbitration (combinational on registered pend):
  - Candidates are sources with pend!=0.
  - Search order starts at rr_ptr+1 and wraps.
  - On a grant, rr_ptr <= granted id.
- FSM, two states:
  - S_IDLE: if any candidate, grant it. At the edge: inc<=1, grant_id<=id, issued_cnt<=issued_cnt+1 (wraps 2^CNT_W-1 -> 0). If GAP>1, go to S_GAP with gap_cnt<=GAP-2; else stay in S_IDLE, so another grant may follow next cycle.
  - S_GAP: inc<=0, no grant. Decrement gap_cnt; when gap_cnt==0, go to S_IDLE.
  - inc is high exactly one cycle per grant. Rising edges are at least GAP cycles apart.
- Latency:
  - req high in cycle 0 -> pend visible cycle 1 -> inc=1 in cycle 2 (idle block, GAP respected).
  - inc and grant_id change only at clock edges; no combinational path from req to inc.
- Conservation: accepted requests = issued incs + sum(pend), always.
- grant_id holds its last value while inc=0.

Decomposition:
- Package cnt_sched_pkg holds:
  - state enum {S_IDLE, S_GAP}
  - localparam ID_W = $clog2(N_REQ)
  - function for the pend next-value/overflow rule
- Sub-module rr_pick: N_REQ-wide round-robin picker.
  - Inputs: candidate vector, pointer.
  - Outputs: one-hot grant, encoded id, any-valid.
  - Purely combinational; reused by other arbiters in the library.

Test Plan:
- GAP=2: req[2] pulse at cycle 0 -> inc=1 at cycle 2 only, grant_id=2, issued_cnt=1, pend[2]=0, busy=0 from cycle 4.
- req=4'b1111 for one cycle, GAP=2 -> inc at cycles 2,4,6,8 with grant_id 0,1,2,3; issued_cnt=4; no pend_ovf.
- GAP=1: req[0] held high 10 cycles, then req[3] one pulse -> inc every cycle from cycle 2; the req[3] grant interleaves at the next round-robin turn. Total incs = 11.
- Overflow: GAP=4, req[1] high 30 cycles -> pend[1] reaches 15, pend_ovf[1]=1. Scoreboard model shows accepted = issued + pend. clr_ovf -> flag 0. A later overflow in the same cycle as clr_ovf -> flag stays 1.
- Saturation corner: pend[1]=15 with req[1] and gnt[1] in the same cycle -> pend[1] stays 15, pend_ovf[1] stays 0.
- Wrap and reset:
  - 259 spaced single requests -> issued_cnt=3.
  - rst for one cycle while pend=4'b0111 -> next cycle inc=0, all pend=0, issued_cnt=0, no further inc without new req.
